// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit decimal output display.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_DIGITS = 3;
    localparam int DATA_W     = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [4*BCD_DIGITS-1:0] dd_adjust(
        input logic [4*BCD_DIGITS-1:0] bcd
    );
        logic [4*BCD_DIGITS-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-high 7-segment pattern, with minus and blank overrides.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (minus) begin
            seg = SEG_MINUS;
        end else if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/output_display_driver.sv
// Binary-to-decimal multiplexed 4-digit 7-segment driver for the CPU output register.
// Define DISPLAY_SIGNED_EN to treat data_in as two's complement with a minus sign on digit 3.
module output_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic              busy
);

    localparam int CW = $clog2(REFRESH_CYCLES);

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       shadow_q, shadow_d;
    logic [DATA_W-1:0]       work_q, work_d;
    logic [4*BCD_DIGITS-1:0] acc_q, acc_d;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [2:0]              iter_q, iter_d;
    logic [3:0]              hun_q, hun_d;
    logic [3:0]              ten_q, ten_d;
    logic [3:0]              one_q, one_d;
    logic [DATA_W-1:0]       mag;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic                    tc;
    logic [3:0]              dig_bcd;
    logic                    dig_blank;
    logic                    dig_minus;
    logic [6:0]              seg_hi;
`ifdef DISPLAY_SIGNED_EN
    logic                    neg_pend_q, neg_pend_d;
    logic                    neg_q, neg_d;

    assign mag = data_in[DATA_W-1] ? (~data_in + 8'd1) : data_in;
`else
    assign mag = data_in;
`endif

    assign adj = dd_adjust(acc_q);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        work_d   = work_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        hun_d    = hun_q;
        ten_d    = ten_q;
        one_d    = one_q;
`ifdef DISPLAY_SIGNED_EN
        neg_pend_d = neg_pend_q;
        neg_d      = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (data_in != shadow_q) begin
                    shadow_d = data_in;
                    work_d   = mag;
                    acc_d    = '0;
                    iter_d   = '0;
                    state_d  = SHIFT;
`ifdef DISPLAY_SIGNED_EN
                    neg_pend_d = data_in[DATA_W-1];
`endif
                end
            end
            SHIFT: begin
                {acc_d, work_d} = {adj[4*BCD_DIGITS-2:0], work_q, 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                hun_d   = acc_q[11:8];
                ten_d   = acc_q[7:4];
                one_d   = acc_q[3:0];
                state_d = IDLE;
`ifdef DISPLAY_SIGNED_EN
                neg_d = neg_pend_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running refresh scanner, unaffected by conversions.
    always_comb begin
        tc    = (cnt_q == CW'(REFRESH_CYCLES - 1));
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        idx_d = tc ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            hun_q    <= '0;
            ten_q    <= '0;
            one_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
`ifdef DISPLAY_SIGNED_EN
            neg_pend_q <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
            hun_q    <= hun_d;
            ten_q    <= ten_d;
            one_q    <= one_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
`ifdef DISPLAY_SIGNED_EN
            neg_pend_q <= neg_pend_d;
            neg_q      <= neg_d;
`endif
        end
    end

    always_comb begin
        dig_bcd   = one_q;
        dig_blank = 1'b0;
        dig_minus = 1'b0;
        unique case (idx_q)
            2'd0: dig_bcd = one_q;
            2'd1: begin
                dig_bcd   = ten_q;
                dig_blank = (hun_q == 4'd0) && (ten_q == 4'd0);
            end
            2'd2: begin
                dig_bcd   = hun_q;
                dig_blank = (hun_q == 4'd0);
            end
            2'd3: begin
`ifdef DISPLAY_SIGNED_EN
                dig_blank = !neg_q;
                dig_minus = neg_q;
`else
                dig_blank = 1'b1;
`endif
            end
            default: dig_blank = 1'b1;
        endcase
    end

    seg7_decoder u_dec (
        .bcd   (dig_bcd),
        .blank (dig_blank),
        .minus (dig_minus),
        .seg   (seg_hi)
    );

    assign seg  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    assign an   = ~(4'b0001 << idx_q);
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_output_display_driver.sv
// Scoreboard bench for output_display_driver: random and directed values
// checked against an arithmetic decimal-display model.
module tb_output_display_driver;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          c0 = 0;
    bit          rst_at_edge = 1'b1;
    bit          prev_busy = 1'b0;
    logic [27:0] cur;
    int          mi;
    logic [3:0]  exp_an;
    exp_t        e;

    always #5 clk = ~clk;

    output_display_driver #(
        .REFRESH_CYCLES (R),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .seg     (seg),
        .an      (an),
        .busy    (busy)
    );

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected active-low segments for all four digits, digit 0 in the low bits.
    function automatic logic [27:0] model(input int v);
        int m;
        bit neg;
        logic [6:0] d0, d1, d2, d3;
        m = v;
        neg = 1'b0;
`ifdef DISPLAY_SIGNED_EN
        if (v >= 128) begin
            neg = 1'b1;
            m = 256 - v;
        end
`endif
        d0 = digit_pat(m % 10);
        d1 = (m < 10) ? 7'b0 : digit_pat((m / 10) % 10);
        d2 = (m < 100) ? 7'b0 : digit_pat(m / 100);
        d3 = neg ? 7'b1000000 : 7'b0;
        return {~d3, ~d2, ~d1, ~d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_at_edge <= reset;
        if (reset) c0 <= cyc + 1;
    end

    initial cur = model(0);

    // Monitor: pops the scoreboard on every completed conversion and
    // checks the scanned display every cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_at_edge) begin
                chk("reset_busy", busy, 0);
                cur = model(0);
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    chk("queue_nonempty", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("commit_cycle", cyc, e.due);
                        cur = model(e.val);
                    end
                end
                prev_busy = busy;
            end
            mi = ((cyc - c0) / R) % 4;
            exp_an = ~(4'b0001 << mi);
            chk("an", an, exp_an);
            chk("seg", seg, cur[mi*7 +: 7]);
        end
    end

    task automatic drive(input int v);
        @(posedge clk);
        #1;
        data_in = v[7:0];
        q.push_back('{v, cyc + 10});
        @(posedge clk);
        #1;
        chk("busy_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", n < 200, 1);
        repeat (4 * R + 1) @(posedge clk);
    endtask

    initial begin
        int v;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_an", an, 4'b1110);
        chk("reset_busy_tb", busy, 0);
        repeat (4 * R + 2) @(posedge clk);

        drive(8'hFF); wait_idle();
        drive(8'h07); wait_idle();
        drive(8'h64); wait_idle();
        drive(8'h80); wait_idle();
        drive(8'h7F); wait_idle();

        // Value changes mid-conversion: both values get committed in turn.
        @(posedge clk);
        #1;
        data_in = 8'h10;
        q.push_back('{16, cyc + 10});
        q.push_back('{32, cyc + 20});
        repeat (3) @(posedge clk);
        #1;
        data_in = 8'h20;
        wait_idle();

        // Reset during a conversion aborts it.
        drive(8'h99);
        @(posedge clk);
        #1;
        q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        data_in = 8'h2A;
        q.push_back('{42, cyc + 10});
        wait_idle();

        // Rewriting the same value must not start a conversion.
        @(posedge clk);
        #1;
        data_in = 8'h2A;
        repeat (2) @(posedge clk);
        #1;
        chk("no_reconvert", busy, 0);

        repeat (20) begin
            v = int'($urandom_range(0, 255));
            if (v == int'(data_in)) v = v ^ 1;
            drive(v);
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
